// File: rtl/abr_loop_ctrl_pkg.sv
// Shared types and constants for the loop sequencer.
// State codes are sparse: every pair of codes differs in at least 3 bits.
package abr_loop_ctrl_pkg;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000000,
    ST_RUN  = 6'b000111,
    ST_DONE = 6'b111000,
    ST_ERR  = 6'b111111
  } state_e;

  localparam int unsigned CNT_STEP = 1;

endpackage

// File: rtl/abr_loop_ctrl_if.sv
// Iteration handshake and hardened-counter control/status bundle.
// The master side is the loop sequencer.
interface abr_loop_ctrl_if #(parameter int Width = 8);

  logic             iter_valid_o;
  logic             iter_ready_i;
  logic [Width-1:0] iter_idx_o;
  logic             cnt_clr_o;
  logic             cnt_set_o;
  logic [Width-1:0] cnt_set_val_o;
  logic             cnt_incr_o;
  logic             cnt_decr_o;
  logic [Width-1:0] cnt_step_o;
  logic [Width-1:0] cnt_i;
  logic             cnt_err_i;

  modport master (
    output iter_valid_o, iter_idx_o, cnt_clr_o, cnt_set_o, cnt_set_val_o,
           cnt_incr_o, cnt_decr_o, cnt_step_o,
    input  iter_ready_i, cnt_i, cnt_err_i
  );

  modport slave (
    input  iter_valid_o, iter_idx_o, cnt_clr_o, cnt_set_o, cnt_set_val_o,
           cnt_incr_o, cnt_decr_o, cnt_step_o,
    output iter_ready_i, cnt_i, cnt_err_i
  );

endinterface

// File: rtl/abr_loop_ctrl_flop.sv
// Plain register with synchronous active-low reset to a fixed value.
// Kept as its own cell so the state encoding survives synthesis.
module abr_loop_ctrl_flop #(
  parameter int           W      = 1,
  parameter logic [W-1:0] RstVal = '0
) (
  input  logic         clk_i,
  input  logic         rst_b,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_b) q_o <= RstVal;
    else        q_o <= d_i;
  end

endmodule

// File: rtl/abr_loop_ctrl.sv
// Loop sequencer: walks a hardened counter from start_idx to limit-1, one
// handshake per index, shadowing the count and trapping on any disagreement.
module abr_loop_ctrl
  import abr_loop_ctrl_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_b,
  input  logic             start_i,
  input  logic [Width-1:0] start_idx_i,
  input  logic [Width-1:0] num_iter_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  abr_loop_ctrl_if.master  bus
);

  localparam int               StW = $bits(state_e);
  localparam logic [Width-1:0] One = Width'(1);

  logic [StW-1:0]   state_raw_q;
  state_e           state_q, state_d;
  logic [Width-1:0] limit_q, limit_d;
  logic [Width-1:0] exp_q, exp_d;
  logic             chk_fail;
  logic             valid, clr, set, incr;
  logic [Width-1:0] set_val;

  abr_loop_ctrl_flop #(.W(StW), .RstVal(ST_IDLE)) u_state_flop (
    .clk_i (clk_i),
    .rst_b (rst_b),
    .d_i   (state_d),
    .q_o   (state_raw_q)
  );
  assign state_q = state_e'(state_raw_q);

  always_ff @(posedge clk_i) begin
    if (!rst_b) begin
      limit_q <= '0;
      exp_q   <= '0;
    end else begin
      limit_q <= limit_d;
      exp_q   <= exp_d;
    end
  end

  // Shadow check while a loop is live; detection suppresses every control
  // output in the same cycle so the counter is never moved by a bad cycle.
  assign chk_fail = bus.cnt_err_i || (bus.cnt_i != exp_q);

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    exp_d   = exp_q;
    valid   = 1'b0;
    clr     = 1'b0;
    set     = 1'b0;
    set_val = '0;
    incr    = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cnt_err_i) begin
          state_d = ST_ERR;
        end else if (start_i) begin
          set     = 1'b1;
          set_val = start_idx_i;
          limit_d = num_iter_i;
          exp_d   = start_idx_i;
          state_d = (start_idx_i < num_iter_i) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        valid  = !chk_fail;
        if (chk_fail) begin
          state_d = ST_ERR;
        end else if (abort_i) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.iter_ready_i) begin
          incr  = 1'b1;
          exp_d = exp_q + One;
          if (bus.cnt_i == limit_q - One) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = !chk_fail && !abort_i;
        clr    = !chk_fail && abort_i;
        state_d = chk_fail ? ST_ERR : ST_IDLE;
      end
      ST_ERR: begin
        err_o = 1'b1;
      end
      default: begin
        err_o   = 1'b1;
        state_d = ST_ERR;
      end
    endcase
  end

  assign bus.iter_valid_o  = valid;
  assign bus.iter_idx_o    = bus.cnt_i;
  assign bus.cnt_clr_o     = clr;
  assign bus.cnt_set_o     = set;
  assign bus.cnt_set_val_o = set_val;
  assign bus.cnt_incr_o    = incr;
  assign bus.cnt_decr_o    = 1'b0;
  assign bus.cnt_step_o    = Width'(CNT_STEP);

endmodule

// File: tb/tb_abr_loop_ctrl.sv
// Bench for abr_loop_ctrl: behavioural up-counter plus an index scoreboard
// filled at loop start and drained on every accepted handshake.
module tb_abr_loop_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] start_idx = '0;
  logic [W-1:0] num_iter = '0;
  logic         busy, done, err;
  logic [W-1:0] cnt_m;
  logic [W-1:0] cnt_off = '0;
  logic         cnt_err_inj = 1'b0;

  int n_vec = 0, n_err = 0, incr_seen = 0, done_seen = 0;
  logic [W-1:0] sb_q[$];

  abr_loop_ctrl_if #(.Width(W)) bus();

  abr_loop_ctrl #(.Width(W)) dut (
    .clk_i       (clk),
    .rst_b       (rst_b),
    .start_i     (start),
    .start_idx_i (start_idx),
    .num_iter_i  (num_iter),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  assign bus.iter_ready_i = ready;
  assign bus.cnt_i        = cnt_m + cnt_off;
  assign bus.cnt_err_i    = cnt_err_inj;

  // Hardened counter stand-in
  always @(posedge clk) begin
    if (!rst_b)                cnt_m <= '0;
    else if (bus.cnt_clr_o)    cnt_m <= '0;
    else if (bus.cnt_set_o)    cnt_m <= bus.cnt_set_val_o;
    else if (bus.cnt_incr_o)   cnt_m <= cnt_m + bus.cnt_step_o;
    else if (bus.cnt_decr_o)   cnt_m <= cnt_m - bus.cnt_step_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b) begin
      if (bus.cnt_incr_o) incr_seen++;
      if (done) done_seen++;
      if (bus.iter_valid_o && !abort) begin
        if (sb_q.size() == 0) chk("sb_occupancy", sb_q.size(), 1);
        else begin
          chk("sb_idx", bus.iter_idx_o, sb_q[0]);
          if (ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_loop(input int idx, input int num);
    start_idx = W'(idx);
    num_iter  = W'(num);
    start     = 1'b1;
    #1;
    chk("start_set", bus.cnt_set_o, 1);
    chk("start_set_val", bus.cnt_set_val_o, idx);
    for (int i = idx; i < num; i++) sb_q.push_back(W'(i));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit toggle, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      step();
      n++;
      if (toggle) ready = ~ready;
      if (done) return;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_valid"}, bus.iter_valid_o, 0);
    chk({tag, "_ctl"}, {bus.cnt_clr_o, bus.cnt_set_o, bus.cnt_incr_o, bus.cnt_decr_o}, 0);
    chk({tag, "_setval"}, bus.cnt_set_val_o, 0);
    chk({tag, "_step"}, bus.cnt_step_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    rst_b = 1'b0;
    step(); step();
    chk_reset_outputs("rst");
    rst_b = 1'b1;
    step();

    // Ascending loop, always ready
    ready = 1'b1; incr_seen = 0;
    start_loop(0, 4);
    wait_done(20, 1'b0, n);
    chk("t1_done_lat", n, 4);
    chk("t1_busy_in_done", busy, 1);
    chk("t1_incr", incr_seen, 4);
    chk("t1_cnt_final", cnt_m, 4);
    chk("t1_sb_drained", sb_q.size(), 0);
    step();
    chk("t1_done_pulse", done, 0);

    // Back-pressure: ready toggles, indices held until taken
    ready = 1'b1;
    start_loop(2, 5);
    wait_done(20, 1'b1, n);
    chk("t2_done_lat", n, 5);
    chk("t2_err", err, 0);
    chk("t2_sb_drained", sb_q.size(), 0);
    ready = 1'b1;
    step();

    // Empty range
    start_loop(6, 6);
    chk("t3_valid", bus.iter_valid_o, 0);
    chk("t3_done", done, 1);
    step();
    chk("t3_done_pulse", done, 0);
    chk("t3_idle", busy, 0);
    chk("t3_cnt", cnt_m, 6);

    // Abort at index 3 beats a simultaneous accept
    incr_seen = 0;
    d0 = done_seen;
    start_loop(0, 8);
    step(); step(); step();
    abort = 1'b1;
    #1;
    chk("t4_idx", bus.iter_idx_o, 3);
    chk("t4_clr", bus.cnt_clr_o, 1);
    chk("t4_no_incr", bus.cnt_incr_o, 0);
    step();
    abort = 1'b0;
    sb_q.delete();
    chk("t4_idle", busy, 0);
    chk("t4_cnt_clr", cnt_m, 0);
    step(); step();
    chk("t4_no_done", done_seen, d0);
    chk("t4_incr", incr_seen, 3);

    // Shadow mismatch mid-loop is fatal and sticky
    start_loop(0, 8);
    step();
    cnt_off = W'(1);
    #1;
    chk("t5_valid_on_det", bus.iter_valid_o, 0);
    chk("t5_incr_on_det", bus.cnt_incr_o, 0);
    step();
    cnt_off = '0;
    chk("t5_err", err, 1);
    chk("t5_valid", bus.iter_valid_o, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ctl", {bus.cnt_clr_o, bus.cnt_set_o, bus.cnt_incr_o, bus.cnt_decr_o}, 0);
    start_idx = W'(1); num_iter = W'(5); start = 1'b1;
    #1;
    chk("t5_start_ignored", bus.cnt_set_o, 0);
    step(); step();
    start = 1'b0;
    chk("t5_err_sticky", err, 1);
    chk("t5_busy_sticky", busy, 0);
    sb_q.delete();
    rst_b = 1'b0; step(); rst_b = 1'b1;
    chk("t5_err_cleared", err, 0);

    // Counter error while idle
    cnt_err_inj = 1'b1;
    step();
    cnt_err_inj = 1'b0;
    chk("t5_idle_cnt_err", err, 1);
    rst_b = 1'b0; step(); rst_b = 1'b1;
    step();

    // Top of range: limit 255, last index 254
    ready = 1'b1;
    start_loop(250, 255);
    wait_done(20, 1'b0, n);
    chk("t6_done_lat", n, 5);
    chk("t6_cnt_final", cnt_m, 255);
    chk("t6_err", err, 0);
    chk("t6_sb_drained", sb_q.size(), 0);
    step();

    // Reset mid-run
    start_loop(0, 10);
    step();
    chk("t6_mid_busy", busy, 1);
    rst_b = 1'b0;
    step();
    chk_reset_outputs("t6_rst");
    rst_b = 1'b1;
    sb_q.delete();
    step();
    chk("t6_cnt_after_rst", cnt_m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/abr_loop_ctrl.md
Name: abr_loop_ctrl

Overview:
Loop sequencer that drives the clr/set/incr/decr control interface of an external hardened up/down counter and consumes its count and error outputs. It issues one iteration handshake per counter value from start_idx to limit-1. It keeps a shadow expected count and cross-checks it against the returned count. On any error it enters a terminal error state. The block sits between the sampler/NTT top-level control FSMs and the counter, so loop indices come from a fault-protected source.

Parameters:
Width, 8, bit width of loop index, limit and counter interface.

Ports:
clk_i  in  1  clock
rst_b  in  1  reset, synchronous, active-low
start_i  in  1  start loop (sampled in IDLE only)
start_idx_i  in  Width  first index
num_iter_i  in  Width  exclusive upper bound (limit)
abort_i  in  1  abandon loop
iter_valid_o  out  1  iteration offered
iter_ready_i  in  1  consumer accepts iteration
iter_idx_o  out  Width  current index (= cnt_i)
busy_o  out  1  loop active
done_o  out  1  one-cycle completion pulse
err_o  out  1  fatal error, sticky
cnt_clr_o  out  1  counter clear
cnt_set_o  out  1  counter set
cnt_set_val_o  out  Width  counter set value
cnt_incr_o  out  1  counter increment
cnt_decr_o  out  1  counter decrement, tied 0
cnt_step_o  out  Width  counter step, constant 1
cnt_i  in  Width  counter current value
cnt_err_i  in  1  counter internal error

Behaviour:
- Reset: state=IDLE, limit_q=0, exp_q=0. All outputs 0, except cnt_step_o=1. Reset is synchronous and active-low: sampled on the clk_i edge.
- States: IDLE, RUN, DONE, ERROR. Sparse encoding, pairwise Hamming distance >=3. Any unlisted encoding -> ERROR.
- IDLE:
  - start_i=1 drives cnt_set_o=1 and cnt_set_val_o=start_idx_i combinationally in the same cycle, and loads limit_q=num_iter_i and exp_q=start_idx_i.
  - Next state is RUN if start_idx_i<num_iter_i, else DONE.
  - start_i outside IDLE is ignored.
- RUN:
  - busy_o=1, iter_valid_o=1, iter_idx_o=cnt_i. First offer is the cycle after start.
  - On iter_valid_o&&iter_ready_i: cnt_incr_o=1 and exp_q<=exp_q+1.
  - If the accepted index = limit_q-1, next state is DONE; otherwise stay in RUN.
  - Wrap: when limit_q=2^Width-1, the last index is 2^Width-2. The counter never saturates within a legal loop.
- DONE: done_o=1 for exactly one cycle, busy_o=1. Next state is IDLE. The counter is left holding the final value.
- abort_i in RUN or DONE: cnt_clr_o=1, no increment, next state IDLE, no done_o. abort_i has priority over the handshake. abort_i in IDLE is ignored.
- Checks, evaluated every cycle outside IDLE and ERROR:
  - cnt_err_i=1 -> ERROR.
  - cnt_i!=exp_q -> ERROR.
  - In IDLE, cnt_err_i alone -> ERROR.
- ERROR: terminal until reset. err_o=1. iter_valid_o, busy_o, done_o and every cnt_* control output = 0.
- Error entry has priority over abort, start and the handshake in the same cycle. err_o rises the cycle after detection.
- iter_valid_o, once raised, is held until accepted, aborted or errored. iter_idx_o is stable while valid.
- Arithmetic: exp_q increments modulo 2^Width. The comparison with limit_q uses unsigned Width-bit values.

Decomposition:
- Package abr_loop_ctrl_pkg holds:
  - the state enum with sparse encodings (4 states, 6-bit codes, min distance 3);
  - the constant for counter step = 1.
- The state register uses the team's flop primitive with reset value IDLE, so the encoding is preserved through synthesis.
- No other sub-module; the counter is instantiated by the parent.

Test Plan:
- start_idx=0, num_iter=4, ready always 1 -> iter_idx 0,1,2,3 in consecutive cycles from start+1; done_o pulse at start+5; cnt_incr_o asserted 4 times.
- start_idx=2, num_iter=5, ready toggling 1,0,1,0,1 -> indices 2,3,4 each held until accepted; done_o after the third acceptance; no ERROR.
- start_idx=6, num_iter=6 -> cnt_set_o with value 6; no iter_valid_o; done_o next cycle.
- Run num_iter=8; at index 3 assert abort_i together with iter_ready_i -> cnt_clr_o=1, no cnt_incr_o, IDLE next cycle, done_o never asserted.
- Mid-loop, force cnt_i to exp_q+1 (or assert cnt_err_i) -> err_o=1 next cycle and stays 1; iter_valid_o=0, all cnt_* controls 0; a subsequent start_i is ignored until rst_b=0.
- Width=8, start_idx=250, num_iter=255 -> indices 250..254, done_o, counter ends at 255, no error; then rst_b low for 1 cycle mid-RUN of a new loop -> all outputs return to reset values at the next edge.
